// File: rtl/mipi_rx_lane_ctrl.sv
// rtl/mipi_rx_lane_ctrl.sv - MIPI D-PHY receive lane LP/HS sequencing controller
module mipi_rx_lane_ctrl #(
    parameter int SETTLE_CYC = 8,
    parameter int SYNC_TMO   = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE,
    input  logic       DRXLPP,
    input  logic       DRXLPN,
    input  logic       SYNC,
    input  logic       ERRSYNC,
    input  logic       NOSYNC,
    output logic       RXLPEN,
    output logic       RXHSEN,
    output logic       HSDESEREN,
    output logic       HSACTIVE,
    output logic       ERR,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_STOP     = 3'd1,
        S_HSRQST   = 3'd2,
        S_SETTLE   = 3'd3,
        S_WAITSYNC = 3'd4,
        S_HSDATA   = 3'd5,
        S_WAITSTOP = 3'd6
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] SYNC_LAST   = 8'(SYNC_TMO - 1);

    state_t     state_q;
    state_t     state_d;
    logic       err_d;
    logic [7:0] cnt_q;
    logic [1:0] lp;

    assign lp    = {DRXLPP, DRXLPN};
    assign STATE = state_q;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        if (!ENABLE) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF:    state_d = S_STOP;
                S_STOP:   if (lp == 2'b01) state_d = S_HSRQST;
                S_HSRQST: begin
                    case (lp)
                        2'b00:   state_d = S_SETTLE;
                        2'b11:   state_d = S_STOP;
                        2'b10: begin
                            state_d = S_STOP;
                            err_d   = 1'b1;
                        end
                        default: state_d = S_HSRQST;
                    endcase
                end
                S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_WAITSYNC;
                S_WAITSYNC: begin
                    // clean sync wins over any simultaneous error indication
                    if (SYNC) begin
                        state_d = S_HSDATA;
                    end else if (ERRSYNC) begin
                        state_d = S_HSDATA;
                        err_d   = 1'b1;
                    end else if (NOSYNC || cnt_q == SYNC_LAST) begin
                        state_d = S_WAITSTOP;
                        err_d   = 1'b1;
                    end
                end
                S_HSDATA, S_WAITSTOP: if (lp == 2'b11) state_d = S_STOP;
                default:  state_d = S_OFF;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // counter restarts on entry to each timed state and saturates otherwise
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= 8'd0;
        end else if (state_d != state_q && (state_d == S_SETTLE || state_d == S_WAITSYNC)) begin
            cnt_q <= 8'd0;
        end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RXLPEN    <= 1'b0;
            RXHSEN    <= 1'b0;
            HSDESEREN <= 1'b0;
            HSACTIVE  <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            RXLPEN    <= (state_d != S_OFF);
            RXHSEN    <= (state_d == S_SETTLE) || (state_d == S_WAITSYNC) || (state_d == S_HSDATA);
            HSDESEREN <= (state_d == S_WAITSYNC) || (state_d == S_HSDATA);
            HSACTIVE  <= (state_d == S_HSDATA);
            ERR       <= err_d;
        end
    end

endmodule

// File: tb/tb_mipi_rx_lane_ctrl.sv
// tb/tb_mipi_rx_lane_ctrl.sv - directed vector bench for mipi_rx_lane_ctrl
module tb_mipi_rx_lane_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, lpp, lpn, sync, errsync, nosync;
    logic       rxlpen, rxhsen, hsdeseren, hsactive, err;
    logic [2:0] state;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic       en;
        logic [1:0] lp;
        logic       sy;
        logic       es;
        logic       ns;
        logic [2:0] st;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    mipi_rx_lane_ctrl #(.SETTLE_CYC(8), .SYNC_TMO(32)) dut (
        .CLK(clk), .RST(rst), .ENABLE(enable), .DRXLPP(lpp), .DRXLPN(lpn),
        .SYNC(sync), .ERRSYNC(errsync), .NOSYNC(nosync),
        .RXLPEN(rxlpen), .RXHSEN(rxhsen), .HSDESEREN(hsdeseren),
        .HSACTIVE(hsactive), .ERR(err), .STATE(state)
    );

    always #5 clk = ~clk;

    // {STATE, RXLPEN, RXHSEN, HSDESEREN, HSACTIVE, ERR}
    function automatic logic [7:0] expect_outs(input logic [2:0] st, input logic er);
        logic lpen, hsen, desen, act;
        lpen  = (st != 3'd0);
        hsen  = (st == 3'd3) || (st == 3'd4) || (st == 3'd5);
        desen = (st == 3'd4) || (st == 3'd5);
        act   = (st == 3'd5);
        return {st, lpen, hsen, desen, act, er};
    endfunction

    function automatic logic [7:0] actual_outs();
        return {state, rxlpen, rxhsen, hsdeseren, hsactive, err};
    endfunction

    function automatic void add(input logic en, input logic [1:0] lp, input logic sy,
                                input logic es, input logic ns, input logic [2:0] st,
                                input logic er);
        vec_t v;
        v.en = en; v.lp = lp; v.sy = sy; v.es = es; v.ns = ns; v.st = st; v.er = er;
        vecs.push_back(v);
    endfunction

    // SETTLE lasts 8 cycles; LP is held at 11 to show it is ignored there
    function automatic void add_settle();
        for (int k = 0; k < 7; k++) add(1, 2'b11, 0, 0, 0, 3'd3, 0);
        add(1, 2'b11, 0, 0, 0, 3'd4, 0);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        enable = v.en; {lpp, lpn} = v.lp; sync = v.sy; errsync = v.es; nosync = v.ns;
        @(posedge clk);
        #1;
        check(name, actual_outs(), expect_outs(v.st, v.er));
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; enable = 0; lpp = 1; lpn = 1; sync = 0; errsync = 0; nosync = 0;

        add(0, 2'b11, 0, 0, 0, 3'd0, 0);
        add(1, 2'b11, 0, 0, 0, 3'd1, 0);
        add(1, 2'b11, 0, 0, 0, 3'd1, 0);
        add(1, 2'b01, 0, 0, 0, 3'd2, 0);
        add(1, 2'b01, 0, 0, 0, 3'd2, 0);
        add(1, 2'b10, 0, 0, 0, 3'd1, 1);
        add(1, 2'b11, 0, 0, 0, 3'd1, 0);
        add(1, 2'b01, 0, 0, 0, 3'd2, 0);
        add(1, 2'b11, 0, 0, 0, 3'd1, 0);
        add(1, 2'b01, 0, 0, 0, 3'd2, 0);
        add(1, 2'b00, 0, 0, 0, 3'd3, 0);
        add_settle();
        add(1, 2'b00, 1, 0, 1, 3'd5, 0);
        add(1, 2'b01, 0, 0, 0, 3'd5, 0);
        add(1, 2'b11, 0, 0, 0, 3'd1, 0);
        add(1, 2'b01, 0, 0, 0, 3'd2, 0);
        add(1, 2'b00, 0, 0, 0, 3'd3, 0);
        add_settle();
        add(1, 2'b00, 0, 1, 0, 3'd5, 1);
        add(1, 2'b00, 0, 0, 0, 3'd5, 0);
        add(0, 2'b00, 0, 0, 0, 3'd0, 0);
        add(1, 2'b11, 0, 0, 0, 3'd1, 0);
        add(1, 2'b01, 0, 0, 0, 3'd2, 0);
        add(1, 2'b00, 0, 0, 0, 3'd3, 0);
        add_settle();
        add(1, 2'b00, 0, 0, 1, 3'd6, 1);
        add(1, 2'b01, 0, 0, 0, 3'd6, 0);
        add(1, 2'b11, 0, 0, 0, 3'd1, 0);
        add(1, 2'b01, 0, 0, 0, 3'd2, 0);
        add(1, 2'b00, 0, 0, 0, 3'd3, 0);
        add_settle();
        for (int k = 0; k < 31; k++) add(1, 2'b00, 0, 0, 0, 3'd4, 0);
        add(1, 2'b00, 0, 0, 0, 3'd6, 1);
        add(1, 2'b00, 0, 0, 0, 3'd6, 0);
        add(1, 2'b11, 0, 0, 0, 3'd1, 0);
        add(1, 2'b01, 0, 0, 0, 3'd2, 0);
        add(0, 2'b10, 0, 0, 0, 3'd0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", actual_outs(), 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec[%0d]", i));

        v.sy = 0; v.es = 0; v.ns = 0; v.er = 0; v.en = 1;
        v.lp = 2'b11; v.st = 3'd1; apply(v, "mid_rst_stop");
        v.lp = 2'b01; v.st = 3'd2; apply(v, "mid_rst_hsrqst");
        v.lp = 2'b00; v.st = 3'd3; apply(v, "mid_rst_settle0");
        v.lp = 2'b00; v.st = 3'd3; apply(v, "mid_rst_settle1");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_no_edge", actual_outs(), 8'h00);
        @(posedge clk);
        #1;
        check("rst_held", actual_outs(), 8'h00);
        @(negedge clk);
        rst = 1'b0; enable = 1; lpp = 1; lpn = 1;
        @(posedge clk);
        #1;
        check("rst_release", actual_outs(), expect_outs(3'd1, 1'b0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mipi_rx_lane_ctrl.md
MIPI_RX_LANE_CTRL -- requirements
Module: mipi_rx_lane_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 8: CLK cycles RXHSEN is held before HSDESEREN asserts; legal 1..255.
REQ-002 SHALL have parameter SYNC_TMO, default 32: max CLK cycles in WAITSYNC before timeout; legal 1..255.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, ports CLK and RST.
REQ-004 CLK  input  1  lane controller clock; all logic rising-edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 ENABLE  input  1  lane enable; 0 forces OFF.
REQ-007 DRXLPP  input  1  LP receiver P output, already synchronized to CLK.
REQ-008 DRXLPN  input  1  LP receiver N output, already synchronized to CLK.
REQ-009 SYNC  input  1  deserializer clean sync-word detect.
REQ-010 ERRSYNC  input  1  deserializer sync detect with single-bit error.
REQ-011 NOSYNC  input  1  deserializer no-sync indication.
REQ-012 RXLPEN  output  1  LP receiver enable.
REQ-013 RXHSEN  output  1  HS receiver enable.
REQ-014 HSDESEREN  output  1  HS deserializer enable.
REQ-015 HSACTIVE  output  1  lane in HS data phase.
REQ-016 ERR  output  1  one-cycle error pulse.
REQ-017 STATE  output  3  current state encoding.

Function
REQ-018 SHALL implement a state machine with encodings OFF=0, STOP=1, HSRQST=2, SETTLE=3, WAITSYNC=4, HSDATA=5, WAITSTOP=6; 7 unused, recovers to OFF.
REQ-019 SHALL register all outputs and decode them from state only (Moore); outputs change one cycle after the causing input edge.
REQ-020 SHALL drive RXLPEN=1 in every state except OFF.
REQ-021 SHALL drive RXHSEN=1 in SETTLE, WAITSYNC and HSDATA only.
REQ-022 SHALL drive HSDESEREN=1 in WAITSYNC and HSDATA only; HSACTIVE=1 in HSDATA only.
REQ-023 OFF: ENABLE=1 -> STOP.
REQ-024 STOP: LP={DRXLPP,DRXLPN}=01 -> HSRQST; otherwise remain.
REQ-025 HSRQST: LP=00 -> SETTLE; LP=11 -> STOP; LP=10 -> STOP with ERR pulse; LP=01 -> remain.
REQ-026 SETTLE: SHALL load an 8-bit counter on entry, ignore LP lines, and enter WAITSYNC after exactly SETTLE_CYC cycles in SETTLE.
REQ-027 WAITSYNC: SYNC=1 -> HSDATA; else ERRSYNC=1 -> HSDATA with ERR pulse; else NOSYNC=1 -> WAITSTOP with ERR pulse; else after SYNC_TMO cycles in WAITSYNC -> WAITSTOP with ERR pulse.
REQ-028 SYNC SHALL take priority over ERRSYNC and NOSYNC in the same cycle.
REQ-029 HSDATA: LP=11 -> STOP; otherwise remain.
REQ-030 WAITSTOP: LP=11 -> STOP; otherwise remain.
REQ-031 ENABLE=0 SHALL force OFF on the next edge from any state, with priority over all other transitions, and no ERR pulse.
REQ-032 ERR SHALL be high for exactly one cycle per error event, registered with the transition.
REQ-033 The counter SHALL not wrap: it holds at terminal count and is reloaded on every SETTLE and WAITSYNC entry.

Reset
REQ-034 RST=1 SHALL asynchronously force state OFF, counter 0, and all outputs 0 (STATE=0).
REQ-035 RST deassertion SHALL take effect on the next CLK edge; mid-HS reset drops RXHSEN/HSDESEREN immediately.

Verification
REQ-036 ENABLE=1, LP 11->01->00, SETTLE_CYC=8 -> RXHSEN rises 1 cycle after LP=00; HSDESEREN rises 8 cycles later.
REQ-037 In WAITSYNC, pulse SYNC -> HSACTIVE=1 next cycle, ERR stays 0; then LP=11 -> STATE=1 and RXHSEN=0 next cycle.
REQ-038 In WAITSYNC, SYNC_TMO=32 with no sync inputs -> ERR pulses once after 32 cycles, STATE=6; LP=11 -> STATE=1.
REQ-039 In HSRQST, LP=10 -> STATE=1 and one-cycle ERR; SYNC and NOSYNC together in WAITSYNC -> STATE=5, no ERR.
REQ-040 ENABLE=0 in HSDATA -> STATE=0, all outputs 0 next cycle; RST asserted mid-SETTLE -> outputs 0 without a clock edge.
